// File: rtl/sdp_rdma_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sdp_rdma_pkg
//  Description : Shared status encodings, FSM state type and field widths
//                for the SDP RDMA ping-pong group controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdp_rdma_pkg;

    // Width of each per-group status field in the register map
    localparam int STATUS_W = 2;

    // Per-group status encodings; value 3 is reserved and never driven
    localparam logic [STATUS_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATUS_W-1:0] ST_RUNNING = 2'd1;
    localparam logic [STATUS_W-1:0] ST_PENDING = 2'd2;

    // Width of the inter-layer gap counter (GAP_CYCLES is limited to 1..15)
    localparam int GAP_CNT_W = 4;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } fsm_state_t;

endpackage : sdp_rdma_pkg
`default_nettype wire

// File: rtl/sdp_rdma_group_slot.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_rdma_group_slot
//  Description : One ping-pong register group: holds the op-enable flag,
//                resolves hw-clear / sw-set / sw-cancel priority and encodes
//                the registered status field from next-state values.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_rdma_group_slot
    import sdp_rdma_pkg::*;
#(
    parameter logic GROUP_IDX = 1'b0
) (
    input  logic                autosa_core_clk,
    input  logic                autosa_core_rstn,
    input  logic                i_producer,
    input  logic                i_op_en_wr,
    input  logic                i_op_en_wr_data,
    input  logic                i_hw_clear,      // op_done accepted in S_BUSY
    input  logic                i_consumer,
    input  logic                i_busy,          // FSM currently in S_BUSY
    input  logic                i_consumer_nxt,
    input  logic                i_busy_nxt,      // FSM enters/stays in S_BUSY next
    output logic                o_op_en,
    output logic [STATUS_W-1:0] o_status
);

    logic                r_op_en;
    logic                w_op_en_nxt;
    logic [STATUS_W-1:0] r_status;
    logic [STATUS_W-1:0] w_status_nxt;
    logic                w_sel;
    logic                w_running;
    logic                w_clear;
    logic                w_run_nxt;

    assign w_sel     = (i_producer == GROUP_IDX);
    assign w_running = i_busy & (i_consumer == GROUP_IDX);
    assign w_clear   = i_hw_clear & (i_consumer == GROUP_IDX);
    assign w_run_nxt = i_busy_nxt & (i_consumer_nxt == GROUP_IDX);

    // Op-enable next value: hw completion beats any same-cycle sw write;
    // a set on an enabled group and a cancel of the running group are no-ops
    always_comb begin
        w_op_en_nxt = r_op_en;
        if (w_clear) begin
            w_op_en_nxt = 1'b0;
        end else if (i_op_en_wr && w_sel) begin
            if (i_op_en_wr_data && !r_op_en) begin
                w_op_en_nxt = 1'b1;
            end else if (!i_op_en_wr_data && !w_running) begin
                w_op_en_nxt = 1'b0;
            end
        end
    end

    // Status is encoded from next-state values so the register lines up
    // with the flop contents it describes
    always_comb begin
        w_status_nxt = ST_PENDING;
        if (!w_op_en_nxt) begin
            w_status_nxt = ST_IDLE;
        end else if (w_run_nxt) begin
            w_status_nxt = ST_RUNNING;
        end
    end

    // Op-enable and status registers
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_op_en  <= 1'b0;
            r_status <= ST_IDLE;
        end else begin
            r_op_en  <= w_op_en_nxt;
            r_status <= w_status_nxt;
        end
    end

    assign o_op_en  = r_op_en;
    assign o_status = r_status;

endmodule : sdp_rdma_group_slot
`default_nettype wire

// File: rtl/sdp_rdma_group_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_rdma_group_ctrl
//  Description : Hardware owner of the SDP RDMA ping-pong register groups.
//                Launches the datapath on the consumer group once enabled,
//                toggles consumer on completion and enforces an idle gap
//                between layers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_rdma_group_ctrl
    import sdp_rdma_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic                autosa_core_clk,
    input  logic                autosa_core_rstn,
    input  logic                i_producer,
    input  logic                i_op_en_wr,
    input  logic                i_op_en_wr_data,
    input  logic                i_op_done,
    output logic                o_consumer,
    output logic [STATUS_W-1:0] o_status_0,
    output logic [STATUS_W-1:0] o_status_1,
    output logic                o_op_start,
    output logic                o_op_group,
    output logic [1:0]          o_done_intr,
    output logic                o_err_unexp_done
);

    localparam logic [GAP_CNT_W-1:0] C_GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    fsm_state_t           r_state;
    fsm_state_t           w_state_nxt;
    logic                 r_consumer;
    logic                 w_consumer_nxt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic [GAP_CNT_W-1:0] w_gap_cnt_nxt;
    logic                 w_op_start;
    logic [1:0]           w_done_intr_nxt;
    logic [1:0]           r_done_intr;
    logic                 r_op_group;
    logic                 r_err_unexp_done;
    logic                 w_busy;
    logic                 w_busy_nxt;
    logic                 w_hw_clear;
    logic [1:0]           w_op_en;
    logic [STATUS_W-1:0]  w_status [2];

    assign w_busy     = (r_state == S_BUSY);
    assign w_busy_nxt = (w_state_nxt == S_BUSY);
    assign w_hw_clear = i_op_done & w_busy;

    // Next-state and launch/completion decode
    always_comb begin
        w_state_nxt     = r_state;
        w_consumer_nxt  = r_consumer;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_op_start      = 1'b0;
        w_done_intr_nxt = 2'b00;
        case (r_state)
            S_IDLE: begin
                // Only the consumer group may launch, so groups alternate
                if (w_op_en[r_consumer]) begin
                    w_op_start  = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_op_done) begin
                    w_done_intr_nxt[r_consumer] = 1'b1;
                    w_consumer_nxt = ~r_consumer;
                    w_gap_cnt_nxt  = C_GAP_LOAD;
                    w_state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM, consumer pointer and gap counter registers
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_state    <= S_IDLE;
            r_consumer <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_consumer <= w_consumer_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    // Launched group, completion interrupt and sticky unexpected-done flag;
    // done_intr is registered so it appears together with the new consumer
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_op_group       <= 1'b0;
            r_done_intr      <= 2'b00;
            r_err_unexp_done <= 1'b0;
        end else begin
            if (w_op_start) begin
                r_op_group <= r_consumer;
            end
            r_done_intr <= w_done_intr_nxt;
            if (i_op_done && !w_busy) begin
                r_err_unexp_done <= 1'b1;
            end
        end
    end

    // One slot per ping-pong group
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            sdp_rdma_group_slot #(
                .GROUP_IDX (1'(gi))
            ) u_slot (
                .autosa_core_clk  (autosa_core_clk),
                .autosa_core_rstn (autosa_core_rstn),
                .i_producer       (i_producer),
                .i_op_en_wr       (i_op_en_wr),
                .i_op_en_wr_data  (i_op_en_wr_data),
                .i_hw_clear       (w_hw_clear),
                .i_consumer       (r_consumer),
                .i_busy           (w_busy),
                .i_consumer_nxt   (w_consumer_nxt),
                .i_busy_nxt       (w_busy_nxt),
                .o_op_en          (w_op_en[gi]),
                .o_status         (w_status[gi])
            );
        end
    endgenerate

    assign o_consumer       = r_consumer;
    assign o_status_0       = w_status[0];
    assign o_status_1       = w_status[1];
    assign o_op_start       = w_op_start;
    assign o_op_group       = r_op_group;
    assign o_done_intr      = r_done_intr;
    assign o_err_unexp_done = r_err_unexp_done;

endmodule : sdp_rdma_group_ctrl
`default_nettype wire

// File: tb/tb_sdp_rdma_group_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdp_rdma_group_ctrl
//  Description : Directed self-checking bench for sdp_rdma_group_ctrl.
//                Inputs change just after the rising edge; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_rdma_group_ctrl;

    logic       autosa_core_clk;
    logic       autosa_core_rstn;
    logic       i_producer;
    logic       i_op_en_wr;
    logic       i_op_en_wr_data;
    logic       i_op_done;
    logic       o_consumer;
    logic [1:0] o_status_0;
    logic [1:0] o_status_1;
    logic       o_op_start;
    logic       o_op_group;
    logic [1:0] o_done_intr;
    logic       o_err_unexp_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sdp_rdma_group_ctrl #(
        .GAP_CYCLES (1)
    ) u_dut (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .i_producer       (i_producer),
        .i_op_en_wr       (i_op_en_wr),
        .i_op_en_wr_data  (i_op_en_wr_data),
        .i_op_done        (i_op_done),
        .o_consumer       (o_consumer),
        .o_status_0       (o_status_0),
        .o_status_1       (o_status_1),
        .o_op_start       (o_op_start),
        .o_op_group       (o_op_group),
        .o_done_intr      (o_done_intr),
        .o_err_unexp_done (o_err_unexp_done)
    );

    initial autosa_core_clk = 1'b0;
    always #5 autosa_core_clk = ~autosa_core_clk;

    // advance to just after the next rising edge
    task automatic step();
        @(posedge autosa_core_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_op_en_wr      = 1'b0;
        i_op_en_wr_data = 1'b0;
        i_op_done       = 1'b0;
    endtask

    task automatic test_reset();
        autosa_core_rstn = 1'b0;
        i_producer = 1'b0;
        clear_inputs();
        repeat (3) @(posedge autosa_core_clk);
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_consumer, o_status_0, o_status_1, o_op_start, o_op_group, o_done_intr, o_err_unexp_done} !== 10'b0)
            $display("FAIL reset_outputs: got %b want %b",
                     {o_consumer, o_status_0, o_status_1, o_op_start, o_op_group, o_done_intr, o_err_unexp_done}, 10'b0);
        else pass_cnt++;
        step();
        autosa_core_rstn = 1'b1;
        repeat (4) step();
    endtask

    // enable group 0 from idle: op_start one cycle after the write
    task automatic test_first_launch();
        i_producer = 1'b0; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_op_start !== 1'b0) $display("FAIL t1_no_early_start: got %b want 0", o_op_start);
        else pass_cnt++;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_op_start !== 1'b1) $display("FAIL t1_op_start: got %b want 1", o_op_start);
        else pass_cnt++;
        chk_cnt++;
        if (o_status_1 !== 2'd0) $display("FAIL t1_status_1: got %0d want 0", o_status_1);
        else pass_cnt++;
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_op_start, o_op_group, o_status_0} !== 4'b0_0_01)
            $display("FAIL t1_running: got start/group/st0 %b want 0001", {o_op_start, o_op_group, o_status_0});
        else pass_cnt++;
    endtask

    // group 0 running, queue group 1, complete group 0, group 1 launches after gap
    task automatic test_pingpong();
        step();
        i_producer = 1'b1; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_status_0, o_status_1} !== {2'd1, 2'd2})
            $display("FAIL t2_pending: got st0/st1 %0d/%0d want 1/2", o_status_0, o_status_1);
        else pass_cnt++;
        step();
        i_op_done = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_done_intr !== 2'b01) $display("FAIL t2_done_intr: got %b want 01", o_done_intr);
        else pass_cnt++;
        chk_cnt++;
        if ({o_consumer, o_status_0, o_op_start} !== 4'b1_00_0)
            $display("FAIL t2_after_done: got cons/st0/start %b want 1000", {o_consumer, o_status_0, o_op_start});
        else pass_cnt++;
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_op_start, o_done_intr} !== 3'b1_00)
            $display("FAIL t2_gap_launch: got start/intr %b want 100", {o_op_start, o_done_intr});
        else pass_cnt++;
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_op_group, o_status_1, o_op_start} !== 4'b1_01_0)
            $display("FAIL t2_group1_running: got grp/st1/start %b want 1010", {o_op_group, o_status_1, o_op_start});
        else pass_cnt++;
    endtask

    // group 1 running: cancel pending group 0 works, cancel of running group 1 ignored
    task automatic test_cancel();
        step();
        i_producer = 1'b0; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        i_op_en_wr_data = 1'b0;
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_status_0 !== 2'd2) $display("FAIL t3_pending0: got %0d want 2", o_status_0);
        else pass_cnt++;
        step();
        i_producer = 1'b1;
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_status_0 !== 2'd0) $display("FAIL t3_cancel0: got %0d want 0", o_status_0);
        else pass_cnt++;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_status_1 !== 2'd1) $display("FAIL t3_cancel_running_ignored: got %0d want 1", o_status_1);
        else pass_cnt++;
        step();
        i_op_done = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_done_intr, o_consumer, o_status_1} !== 5'b10_0_00)
            $display("FAIL t3_done1: got intr/cons/st1 %b want 10000", {o_done_intr, o_consumer, o_status_1});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge autosa_core_clk);
            chk_cnt++;
            if ({o_op_start, o_err_unexp_done} !== 2'b00)
                $display("FAIL t3_no_launch_%0d: got start/err %b want 00", i, {o_op_start, o_err_unexp_done});
            else pass_cnt++;
        end
    endtask

    // op_done and an enable write to the running group in the same cycle
    task automatic test_clear_wins();
        step();
        i_producer = 1'b0; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_op_start !== 1'b1) $display("FAIL t4_launch0: got %b want 1", o_op_start);
        else pass_cnt++;
        step();
        i_op_done = 1'b1; i_producer = 1'b0; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_status_0, o_consumer, o_done_intr} !== 5'b00_1_01)
            $display("FAIL t4_clear_wins: got st0/cons/intr %b want 00101", {o_status_0, o_consumer, o_done_intr});
        else pass_cnt++;
        step();
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_status_0, o_op_start} !== 3'b00_0)
            $display("FAIL t4_stays_idle: got st0/start %b want 000", {o_status_0, o_op_start});
        else pass_cnt++;
    endtask

    // op_done while idle raises the sticky error and changes nothing else
    task automatic test_unexp_done();
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_err_unexp_done !== 1'b0) $display("FAIL t5_err_before: got %b want 0", o_err_unexp_done);
        else pass_cnt++;
        step();
        i_op_done = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_err_unexp_done, o_consumer, o_status_0, o_status_1, o_done_intr} !== 8'b1_1_00_00_00)
            $display("FAIL t5_err_set: got err/cons/st0/st1/intr %b want 11000000",
                     {o_err_unexp_done, o_consumer, o_status_0, o_status_1, o_done_intr});
        else pass_cnt++;
        repeat (2) step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_err_unexp_done !== 1'b1) $display("FAIL t5_err_sticky: got %b want 1", o_err_unexp_done);
        else pass_cnt++;
    endtask

    // reset while busy clears everything at once; afterwards group 1 alone cannot launch
    task automatic test_reset_busy();
        step();
        i_producer = 1'b1; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if (o_op_start !== 1'b1) $display("FAIL t6_launch1: got %b want 1", o_op_start);
        else pass_cnt++;
        step();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_status_1, o_op_group} !== 3'b01_1)
            $display("FAIL t6_busy1: got st1/grp %b want 011", {o_status_1, o_op_group});
        else pass_cnt++;
        #1;
        autosa_core_rstn = 1'b0;
        #1;
        chk_cnt++;
        if ({o_consumer, o_status_0, o_status_1, o_op_start, o_op_group, o_done_intr, o_err_unexp_done} !== 10'b0)
            $display("FAIL t6_async_reset: got %b want %b",
                     {o_consumer, o_status_0, o_status_1, o_op_start, o_op_group, o_done_intr, o_err_unexp_done}, 10'b0);
        else pass_cnt++;
        repeat (2) step();
        autosa_core_rstn = 1'b1;
        step();
        i_producer = 1'b1; i_op_en_wr = 1'b1; i_op_en_wr_data = 1'b1;
        step();
        clear_inputs();
        @(negedge autosa_core_clk);
        chk_cnt++;
        if ({o_status_1, o_consumer, o_op_start} !== 4'b10_0_0)
            $display("FAIL t6_pending1: got st1/cons/start %b want 1000", {o_status_1, o_consumer, o_op_start});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge autosa_core_clk);
            chk_cnt++;
            if ({o_op_start, o_done_intr} !== 3'b000)
                $display("FAIL t6_no_start_%0d: got start/intr %b want 000", i, {o_op_start, o_done_intr});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_first_launch();
        test_pingpong();
        test_cancel();
        test_clear_wins();
        test_unexp_done();
        test_reset_busy();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_sdp_rdma_group_ctrl
`default_nettype wire
